// File: rtl/horloge_ctrl.sv
// Digital clock controller: 1 Hz prescaler, HH:MM:SS counters and a
// three-state set mode (RUN -> SET_HOUR -> SET_MIN) driven by button pulses.
module horloge_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       tick_1hz,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2 - 1);

  // Encoding is the mode output; 2'b11 is never entered.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;
  logic          presc_at_max;

  assign presc_at_max = (presc_q == P_MAX);

  always_comb begin
    state_d = state_q;
    presc_d = presc_at_max ? '0 : presc_q + 1'b1;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    blink_d = 1'b0;
    tick_d  = 1'b0;

    case (state_q)
      RUN: begin
        if (presc_at_max) begin
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d  = 6'd0;
              hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        // btn_inc is deliberately ignored here, including on a tick cycle.
        if (btn_mode) begin
          state_d = SET_HOUR;
          sec_d   = 6'd0;
          presc_d = '0;
        end
      end
      SET_HOUR: begin
        blink_d = (presc_q == P_HALF || presc_at_max) ? ~blink_q : blink_q;
        if (btn_mode) begin
          state_d = SET_MIN;
        end else if (btn_inc) begin
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
      end
      SET_MIN: begin
        blink_d = (presc_q == P_HALF || presc_at_max) ? ~blink_q : blink_q;
        if (btn_mode) begin
          state_d = RUN;
          presc_d = '0;
          blink_d = 1'b0;
        end else if (btn_inc) begin
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: begin
        state_d = RUN;
        presc_d = '0;
      end
    endcase

    // Registered tick: high for the whole cycle in which the prescaler sits at max in RUN.
    tick_d = (state_d == RUN) && (presc_d == P_MAX);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end

  assign tick_1hz = tick_q;
  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;
  assign mode     = state_q;
  assign blink    = blink_q & (state_q != RUN);

endmodule
